// File: rtl/approx_mul_sweep_checker_if.sv
// Bus between the sweep checker and the environment: multiplier operand/result pair plus control and metrics.
// master = checker side, slave = environment / approximate multiplier side.
interface approx_mul_sweep_checker_if #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 4,
  parameter int SUM_W = 8
);
  logic                start;
  logic [2*IN_W-1:0]   sweep_in;
  logic [OUT_W-1:0]    approx_out;
  logic                busy;
  logic                done;
  logic [OUT_W-1:0]    max_err;
  logic [SUM_W-1:0]    err_sum;
  logic [2*IN_W:0]     mism_cnt;
  logic                et_fail;
  logic [2*IN_W-1:0]   fail_vec;

  modport master (
    input  start, approx_out,
    output sweep_in, busy, done, max_err, err_sum, mism_cnt, et_fail, fail_vec
  );

  modport slave (
    output start, approx_out,
    input  sweep_in, busy, done, max_err, err_sum, mism_cnt, et_fail, fail_vec
  );
endinterface

// File: rtl/approx_mul_sweep_checker.sv
// Exhaustive-sweep error checker for a combinational approximate multiplier.
// Optional macro SWEEP_STOP_ON_FAIL_EN: abort the sweep on the first error above ET.
module approx_mul_sweep_checker #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 4,
  parameter int ET    = 4,
  parameter int SUM_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  approx_mul_sweep_checker_if.master  bus
);
  localparam int VEC_W  = 2 * IN_W;
  localparam int CNT_W  = VEC_W + 1;
  localparam int SUM_XW = SUM_W + 1;
  localparam logic [VEC_W-1:0] LAST_VEC = '1;
  localparam logic [OUT_W-1:0] ET_V     = OUT_W'(ET);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [VEC_W-1:0]   sweep_reg, sweep_next;
  logic               s1_valid_reg, s1_valid_next;
  logic [VEC_W-1:0]   s1_vec_reg;
  logic [OUT_W-1:0]   s1_approx_reg;
  logic [OUT_W-1:0]   max_err_reg;
  logic [SUM_W-1:0]   err_sum_reg;
  logic [CNT_W-1:0]   mism_cnt_reg;
  logic               et_fail_reg;
  logic [VEC_W-1:0]   fail_vec_reg;

  logic               start_ok;
  logic [OUT_W-1:0]   a_ext, b_ext, exact, err;
  logic [SUM_XW-1:0]  sum_wide;
  logic               first_fail, stop_now;
  logic               busy_o, done_o;

  assign start_ok = bus.start && (state_reg == IDLE || state_reg == DONE);

  // Stage 2: error of the vector held in stage 1
  assign a_ext      = OUT_W'(s1_vec_reg[IN_W-1:0]);
  assign b_ext      = OUT_W'(s1_vec_reg[VEC_W-1:IN_W]);
  assign exact      = a_ext * b_ext;
  assign err        = (exact >= s1_approx_reg) ? exact - s1_approx_reg : s1_approx_reg - exact;
  assign sum_wide   = {1'b0, err_sum_reg} + SUM_XW'(err);
  assign first_fail = s1_valid_reg && (err > ET_V) && !et_fail_reg;

`ifdef SWEEP_STOP_ON_FAIL_EN
  assign stop_now = first_fail;
`else
  assign stop_now = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (bus.start) state_next = SWEEP;
      SWEEP: begin
        if (stop_now)                    state_next = DONE;
        else if (sweep_reg == LAST_VEC)  state_next = DRAIN;
      end
      // One-deep pipeline: the last vector is accumulated on the edge leaving DRAIN
      DRAIN:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_reg == SWEEP) || (state_reg == DRAIN);
    done_o = (state_reg == DONE);
  end

  // Counter restarts at 0 on entry to SWEEP and parks at 0 everywhere else
  always_comb begin
    sweep_next    = '0;
    s1_valid_next = (state_reg == SWEEP) && !stop_now;
    if (state_next == SWEEP)
      sweep_next = (state_reg == SWEEP) ? sweep_reg + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_reg     <= '0;
      s1_valid_reg  <= 1'b0;
      s1_vec_reg    <= '0;
      s1_approx_reg <= '0;
    end else begin
      sweep_reg     <= sweep_next;
      s1_valid_reg  <= s1_valid_next;
      s1_vec_reg    <= sweep_reg;
      s1_approx_reg <= bus.approx_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_err_reg  <= '0;
      err_sum_reg  <= '0;
      mism_cnt_reg <= '0;
      et_fail_reg  <= 1'b0;
      fail_vec_reg <= '0;
    end else if (start_ok) begin
      max_err_reg  <= '0;
      err_sum_reg  <= '0;
      mism_cnt_reg <= '0;
      et_fail_reg  <= 1'b0;
      fail_vec_reg <= '0;
    end else if (s1_valid_reg) begin
      if (err > max_err_reg) max_err_reg <= err;
      err_sum_reg  <= sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
      mism_cnt_reg <= mism_cnt_reg + CNT_W'(err != '0);
      if (first_fail) begin
        et_fail_reg  <= 1'b1;
        fail_vec_reg <= s1_vec_reg;
      end
    end
  end

  assign bus.sweep_in = sweep_reg;
  assign bus.busy     = busy_o;
  assign bus.done     = done_o;
  assign bus.max_err  = max_err_reg;
  assign bus.err_sum  = err_sum_reg;
  assign bus.mism_cnt = mism_cnt_reg;
  assign bus.et_fail  = et_fail_reg;
  assign bus.fail_vec = fail_vec_reg;
endmodule

// File: tb/tb_approx_mul_sweep_checker.sv
// Self-checking bench for approx_mul_sweep_checker: table of sweeps (fixed + randomized LUT multipliers)
// plus hand-written reset-abort, start re-pulse and restart-from-DONE sequences.
`timescale 1ns/1ps
module tb_approx_mul_sweep_checker;
  localparam int IN_W = 2, OUT_W = 4, ET = 4, SUM_W = 8;
  localparam int NVEC = 16, NROWS = 7;
  localparam int M_EXACT = 0, M_ZERO = 1, M_ONES = 2, M_LUT = 3;

  typedef struct {
    int mode;
    int max_err;
    int err_sum;
    int mism;
    int et_fail;
    int fail_vec;
    int latency;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cur_mode;
  int   lut[NVEC];
  int   lut_tab[NROWS][NVEC];
  vec_t tbl[NROWS];
  int   a_op, b_op;

  always #5 clk = ~clk;

  approx_mul_sweep_checker_if #(.IN_W(IN_W), .OUT_W(OUT_W), .SUM_W(SUM_W)) bus();

  approx_mul_sweep_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(ET), .SUM_W(SUM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural stand-in for the approximate multiplier
  assign a_op = int'(bus.sweep_in) % 4;
  assign b_op = int'(bus.sweep_in) / 4;
  always_comb begin
    bus.approx_out = '0;
    case (cur_mode)
      M_EXACT: bus.approx_out = OUT_W'(a_op * b_op);
      M_ZERO:  bus.approx_out = '0;
      M_ONES:  bus.approx_out = '1;
      default: bus.approx_out = OUT_W'(lut[bus.sweep_in]);
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the vectors in ascending order with plain integer arithmetic
  function automatic vec_t model(input int mode, input int tab[NVEC]);
    vec_t r;
    r.mode = mode; r.max_err = 0; r.err_sum = 0; r.mism = 0;
    r.et_fail = 0; r.fail_vec = 0; r.latency = NVEC + 1;
    for (int k = 0; k < NVEC; k++) begin
      int prod, apx, e;
      prod = (k % 4) * (k / 4);
      apx  = (mode == M_EXACT) ? prod : (mode == M_ZERO) ? 0 : (mode == M_ONES) ? 15 : tab[k];
      e    = (prod > apx) ? prod - apx : apx - prod;
      if (e > r.max_err) r.max_err = e;
      r.err_sum = (r.err_sum + e > 255) ? 255 : r.err_sum + e;
      if (e != 0) r.mism++;
      if (e > ET && r.et_fail == 0) begin
        r.et_fail  = 1;
        r.fail_vec = k;
`ifdef SWEEP_STOP_ON_FAIL_EN
        r.latency = k + 2;
        break;
`endif
      end
    end
    return r;
  endfunction

  task automatic run_sweep(input vec_t e, input string tag, input bit repulse);
    int cycles;
    int last_chk;
    bit seq_bad;
    cycles   = 0;
    seq_bad  = 1'b0;
    last_chk = (e.latency - 2 < NVEC - 1) ? e.latency - 2 : NVEC - 1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_clear"}, 32'(bus.mism_cnt), 32'd0);
    while (!bus.done && cycles < 100) begin
      if (cycles <= last_chk && int'(bus.sweep_in) != cycles) seq_bad = 1'b1;
      bus.start = repulse && (cycles == 5);
      @(posedge clk); #1;
      cycles++;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 32'(cycles), 32'(e.latency));
    check({tag, "_sweep_seq"}, 32'(seq_bad), 32'd0);
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_max_err"}, 32'(bus.max_err), 32'(e.max_err));
    check({tag, "_err_sum"}, 32'(bus.err_sum), 32'(e.err_sum));
    check({tag, "_mism_cnt"}, 32'(bus.mism_cnt), 32'(e.mism));
    check({tag, "_et_fail"}, 32'(bus.et_fail), 32'(e.et_fail));
    check({tag, "_fail_vec"}, 32'(bus.fail_vec), 32'(e.fail_vec));
    $display("sweep %s: cycles=%0d max_err=%0d err_sum=%0d mism_cnt=%0d et_fail=%0d fail_vec=%0d",
             tag, cycles, bus.max_err, bus.err_sum, bus.mism_cnt, bus.et_fail, bus.fail_vec);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_sweep_in"}, 32'(bus.sweep_in), 32'd0);
    check({tag, "_max_err"}, 32'(bus.max_err), 32'd0);
    check({tag, "_err_sum"}, 32'(bus.err_sum), 32'd0);
    check({tag, "_mism_cnt"}, 32'(bus.mism_cnt), 32'd0);
    check({tag, "_et_fail"}, 32'(bus.et_fail), 32'd0);
    check({tag, "_fail_vec"}, 32'(bus.fail_vec), 32'd0);
  endtask

  initial begin
    // Fixed rows: expected metrics straight from the multiplier truth table
    tbl[0] = '{M_EXACT, 0, 0, 0, 0, 0, 17};
`ifdef SWEEP_STOP_ON_FAIL_EN
    tbl[1] = '{M_ZERO, 6, 18, 6, 1, 11, 13};
    tbl[2] = '{M_ONES, 15, 15, 1, 1, 0, 2};
`else
    tbl[1] = '{M_ZERO, 9, 36, 9, 1, 11, 17};
    tbl[2] = '{M_ONES, 15, 204, 16, 1, 0, 17};
`endif
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < NVEC; k++) lut_tab[r][k] = 0;
    for (int r = 3; r < NROWS; r++) begin
      for (int k = 0; k < NVEC; k++)
        lut_tab[r][k] = ($urandom_range(0, 1) == 1) ? (k % 4) * (k / 4) : int'($urandom_range(0, 15));
      tbl[r] = model(M_LUT, lut_tab[r]);
    end

    rst = 1'b1;
    bus.start = 1'b0;
    cur_mode = M_EXACT;
    lut = lut_tab[0];
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < NROWS; r++) begin
      cur_mode = tbl[r].mode;
      lut = lut_tab[r];
      run_sweep(tbl[r], $sformatf("row%0d", r), 1'b0);
    end

    // start re-pulsed mid-sweep is ignored; start from DONE repeats identically
    cur_mode = M_ZERO;
    run_sweep(tbl[1], "repulse", 1'b1);
    run_sweep(tbl[1], "restart", 1'b0);

    // Asynchronous reset at cycle 8 of a sweep aborts immediately
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    run_sweep(tbl[1], "after_reset", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
